router_pkt_src: RTL

Store-and-forward packet source that drives the input side of the router_1x3 packet interface. It accepts a packet request (destination port, payload length), collects the payload bytes from an upstream byte stream into an internal buffer, and emits a complete packet to the router: header byte, payload bytes, then the parity byte. It obeys the router's `busy` back-pressure. It is the transmitting end of the protocol that `router_reg` and the router FSM receive, and it serves both as the design's ingress framer and as a reusable bench driver.

---
 rtl/router_pkt_src.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - store-and-forward packet framer driving the router_1x3 input side
module router_pkt_src #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       req_bad_parity,
    output logic       req_err,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [2:0] state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic       bad_q;
    logic [5:0] count;
    logic [5:0] idx;
    logic [7:0] parity;
    logic [3:0] gap_cnt;
    logic [7:0] mem [0:63];

    logic load_fire;
    assign load_fire = (state == S_LOAD) && pl_valid && pl_ready;

    // Payload buffer has no reset; its contents are only read after being written.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            mem[count] <= pl_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            addr_q    <= 2'd0;
            len_q     <= 6'd0;
            bad_q     <= 1'b0;
            count     <= 6'd0;
            idx       <= 6'd0;
            parity    <= 8'h00;
            gap_cnt   <= 4'd0;
            req_ready <= 1'b1;
            pl_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            req_err   <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            req_err  <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr;
                        len_q  <= req_len;
                        bad_q  <= req_bad_parity;
                        if (req_len == 6'd0 || req_addr == 2'd3) begin
                            req_err <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            req_ready <= 1'b0;
                            pl_ready  <= 1'b1;
                            count     <= 6'd0;
                            parity    <= {req_len, req_addr};
                        end
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        parity <= parity ^ pl_data;
                        count  <= count + 6'd1;
                        if (count == len_q - 6'd1) begin
                            state     <= S_HEADER;
                            pl_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= {len_q, addr_q};
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        state    <= S_PAYLOAD;
                        idx      <= 6'd0;
                        data_out <= mem[0];
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        if (idx == len_q - 6'd1) begin
                            state     <= S_PARITY;
                            pkt_valid <= 1'b0;
                            data_out  <= bad_q ? ~parity : parity;
                        end else begin
                            idx      <= idx + 6'd1;
                            data_out <= mem[idx + 6'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        state    <= S_GAP;
                        data_out <= 8'h00;
                        pkt_done <= 1'b1;
                        gap_cnt  <= 4'd0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    pl_ready  <= 1'b0;
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                end
            endcase
        end
    end

endmodule
